mem_stage: RTL and testbench

- Memory-access stage plus MEM/WB pipeline register of the 5-stage core.
- Consumes the EX/MEM register outputs: control bits, ALU result used as the address, store data, and the destination register.
- Performs byte/half/word stores and loads on an internal byte-addressable data RAM, sign- or zero-extends load data, and registers everything the write-back stage needs.
- Honours the debug-unit step/stall input the same way the other pipeline registers do.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage and MEM/WB pipeline register.
//   Byte/half/word stores and loads on an internal little-endian,
//   byte-addressable data RAM. Loads are sign- or zero-extended. Everything the
//   write-back stage needs is registered. i_step = 1 freezes the stage: no RAM
//   write, and the pipeline outputs and the error counter hold.
//
//   Optional macro MEM_DBG_PORT_EN:
//     defined   : o_dbg_data <= RAM[i_dbg_addr] on every edge, independent of i_step
//     undefined : o_dbg_data is constant 0 and there is no second read path
//
// Ports
//   clk           clock, all state on rising edge
//   i_reset       asynchronous, active-high reset (RAM contents are kept)
//   i_step        1 = hold, 0 = advance
//   i_mem2reg     load / write-back selects load data
//   i_memWrite    store request
//   i_regWrite    write-back enable
//   i_width       00 byte, 01 half, 1x word
//   i_sign_flag   1 = sign-extend loads
//   i_result      ALU result, used as the byte address
//   i_data4Mem    store data, right-aligned
//   i_write_reg   destination register
//   i_dbg_addr    debug word address
//   o_mem2reg, o_regWrite, o_result, o_read_data, o_write_reg : MEM/WB register
//   o_misaligned  1 for the cycle after a misaligned access
//   o_err_count   saturating count of misaligned accesses
//   o_dbg_data    registered debug read of a RAM word
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic               o_misaligned,
    output logic [7:0]         o_err_count,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int NB_LANE = NB_DATA / 8;

    logic [NB_DATA-1:0] r_mem [0:(1 << NB_ADDR) - 1];

    logic               r_mem2reg;
    logic               r_regWrite;
    logic [NB_DATA-1:0] r_result;
    logic [NB_DATA-1:0] r_read_data;
    logic [NB_REG-1:0]  r_write_reg;
    logic               r_misaligned;
    logic [7:0]         r_err_count;

    logic [NB_ADDR-1:0] w_idx;
    logic [1:0]         w_lane;
    logic [NB_DATA-1:0] w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_bad_align;
    logic               w_access;
    logic               w_mis;
    logic [NB_DATA-1:0] w_ext;
    logic [NB_DATA-1:0] w_load;
    logic [NB_LANE-1:0] w_be;
    logic [NB_DATA-1:0] w_wdata;
    logic               w_we;

    // Address bits above the RAM range are dropped, so addresses wrap.
    assign w_idx  = i_result[NB_ADDR+1:2];
    assign w_lane = i_result[1:0];

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_bad_align = 1'b0;
        case (i_width)
            2'b00:   w_bad_align = 1'b0;
            2'b01:   w_bad_align = w_lane[0];
            default: w_bad_align = |w_lane;
        endcase
    end

    assign w_access = i_memWrite | i_mem2reg;
    assign w_mis    = w_access & w_bad_align;

    always_comb begin
        w_ext = '0;
        case (i_width)
            2'b00:   w_ext = {{(NB_DATA-8){i_sign_flag & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{(NB_DATA-16){i_sign_flag & w_half[15]}}, w_half};
            default: w_ext = w_word;
        endcase
    end

    assign w_load = (i_mem2reg & ~w_mis) ? w_ext : '0;

    // Store data is replicated across all lanes; the byte enables pick the
    // lanes that actually change.
    always_comb begin
        w_be    = '0;
        w_wdata = i_data4Mem;
        case (i_width)
            2'b00: begin
                w_be    = NB_LANE'(1) << w_lane;
                w_wdata = {NB_LANE{i_data4Mem[7:0]}};
            end
            2'b01: begin
                w_be    = NB_LANE'(2'b11) << {w_lane[1], 1'b0};
                w_wdata = {(NB_LANE/2){i_data4Mem[15:0]}};
            end
            default: begin
                w_be    = '1;
                w_wdata = i_data4Mem;
            end
        endcase
    end

    assign w_we = ~i_step & i_memWrite & ~w_mis;

    // RAM has no reset; its contents survive i_reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < NB_LANE; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_mem2reg    <= 1'b0;
            r_regWrite   <= 1'b0;
            r_result     <= '0;
            r_read_data  <= '0;
            r_write_reg  <= '0;
            r_misaligned <= 1'b0;
            r_err_count  <= '0;
        end else if (!i_step) begin
            r_mem2reg    <= i_mem2reg;
            r_regWrite   <= i_regWrite & ~(i_mem2reg & w_mis);
            r_result     <= i_result;
            r_read_data  <= w_load;
            r_write_reg  <= i_write_reg;
            r_misaligned <= w_mis;
            if (w_mis && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_mem2reg    = r_mem2reg;
    assign o_regWrite   = r_regWrite;
    assign o_result     = r_result;
    assign o_read_data  = r_read_data;
    assign o_write_reg  = r_write_reg;
    assign o_misaligned = r_misaligned;
    assign o_err_count  = r_err_count;

`ifdef MEM_DBG_PORT_EN
    logic [NB_DATA-1:0] r_dbg_data;
    logic               w_unused;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_mem[i_dbg_addr];
        end
    end

    assign o_dbg_data = r_dbg_data;
    assign w_unused   = ^i_result[NB_DATA-1:NB_ADDR+2];
`else
    logic w_unused;

    assign o_dbg_data = '0;
    assign w_unused   = ^{i_result[NB_DATA-1:NB_ADDR+2], i_dbg_addr};
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        i_reset;
    logic        i_step;
    logic        i_mem2reg;
    logic        i_memWrite;
    logic        i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic [31:0] i_result;
    logic [31:0] i_data4Mem;
    logic [4:0]  i_write_reg;
    logic [7:0]  i_dbg_addr;
    logic        o_mem2reg;
    logic        o_regWrite;
    logic [31:0] o_result;
    logic [31:0] o_read_data;
    logic [4:0]  o_write_reg;
    logic        o_misaligned;
    logic [7:0]  o_err_count;
    logic [31:0] o_dbg_data;

    int n_total = 0;
    int n_pass  = 0;

    mem_stage #(.NB_DATA(32), .NB_REG(5), .NB_ADDR(8)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_step       (i_step),
        .i_mem2reg    (i_mem2reg),
        .i_memWrite   (i_memWrite),
        .i_regWrite   (i_regWrite),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_result     (i_result),
        .i_data4Mem   (i_data4Mem),
        .i_write_reg  (i_write_reg),
        .i_dbg_addr   (i_dbg_addr),
        .o_mem2reg    (o_mem2reg),
        .o_regWrite   (o_regWrite),
        .o_result     (o_result),
        .o_read_data  (o_read_data),
        .o_write_reg  (o_write_reg),
        .o_misaligned (o_misaligned),
        .o_err_count  (o_err_count),
        .o_dbg_data   (o_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One clock edge; returns 1 time unit after it so outputs are sampled
    // away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mw, input logic m2r, input logic rw,
                         input logic [1:0] wd, input logic sg,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wreg);
        i_memWrite  = mw;
        i_mem2reg   = m2r;
        i_regWrite  = rw;
        i_width     = wd;
        i_sign_flag = sg;
        i_result    = addr;
        i_data4Mem  = data;
        i_write_reg = wreg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        i_reset    = 1'b1;
        i_step     = 1'b0;
        i_dbg_addr = 8'd4;
        idle();
        tick();
        check("rst_mem2reg",  {31'b0, o_mem2reg}, 32'h0);
        check("rst_regwrite", {31'b0, o_regWrite}, 32'h0);
        check("rst_result",   o_result, 32'h0);
        check("rst_readdata", o_read_data, 32'h0);
        check("rst_wreg",     {27'b0, o_write_reg}, 32'h0);
        check("rst_mis",      {31'b0, o_misaligned}, 32'h0);
        check("rst_err",      {24'b0, o_err_count}, 32'h0);
        check("rst_dbg",      o_dbg_data, 32'h0);
        #2 i_reset = 1'b0;

        // word store / load
        drive(1, 0, 0, 2'b11, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        tick();
        check("sw_result",   o_result, 32'h10);
        check("sw_readdata", o_read_data, 32'h0);
        check("sw_mis",      {31'b0, o_misaligned}, 32'h0);
        drive(0, 1, 1, 2'b11, 0, 32'h10, 32'h0, 5'd5);
        tick();
        check("lw_data",     o_read_data, 32'hDEADBEEF);
        check("lw_regwrite", {31'b0, o_regWrite}, 32'h1);
        check("lw_wreg",     {27'b0, o_write_reg}, 32'd5);
        check("lw_mem2reg",  {31'b0, o_mem2reg}, 32'h1);
        drive(0, 1, 0, 2'b11, 0, 32'h10, 32'h0, 5'd6);
        tick();
        check("lw_regwrite0", {31'b0, o_regWrite}, 32'h0);
        // address wrap: bit 10 is above the RAM range
        drive(0, 1, 1, 2'b11, 0, 32'h410, 32'h0, 5'd5);
        tick();
        check("lw_wrap", o_read_data, 32'hDEADBEEF);

        // byte store / loads
        drive(1, 0, 0, 2'b00, 0, 32'h13, 32'h12345680, 5'd0);
        tick();
        drive(0, 1, 1, 2'b00, 1, 32'h13, 32'h0, 5'd1);
        tick();
        check("lb_sign", o_read_data, 32'hFFFFFF80);
        drive(0, 1, 1, 2'b00, 0, 32'h13, 32'h0, 5'd1);
        tick();
        check("lbu", o_read_data, 32'h00000080);
        drive(0, 1, 1, 2'b11, 1, 32'h10, 32'h0, 5'd1);
        tick();
        check("lw_after_sb", o_read_data, 32'h80ADBEEF);
        drive(0, 1, 1, 2'b00, 1, 32'h11, 32'h0, 5'd1);
        tick();
        check("lb_lane1_sign", o_read_data, 32'hFFFFFFBE);

        // half store / loads
        drive(1, 0, 0, 2'b11, 0, 32'h10, 32'h0, 5'd0);
        tick();
        drive(1, 0, 0, 2'b01, 0, 32'h12, 32'hFFFF1234, 5'd0);
        tick();
        drive(0, 1, 1, 2'b11, 0, 32'h10, 32'h0, 5'd2);
        tick();
        check("lw_after_sh", o_read_data, 32'h12340000);
        drive(0, 1, 1, 2'b01, 0, 32'h12, 32'h0, 5'd2);
        tick();
        check("lhu", o_read_data, 32'h00001234);
        drive(1, 0, 0, 2'b00, 0, 32'h10, 32'hFFFFFFA5, 5'd0);
        tick();
        drive(0, 1, 1, 2'b01, 1, 32'h10, 32'h0, 5'd2);
        tick();
        check("lh_lane0_zero_hi", o_read_data, 32'h000000A5);
        drive(1, 0, 0, 2'b01, 0, 32'h16, 32'h0000C001, 5'd0);
        tick();
        drive(0, 1, 1, 2'b01, 1, 32'h16, 32'h0, 5'd2);
        tick();
        check("lh_sign", o_read_data, 32'hFFFFC001);

        // misaligned accesses
        drive(1, 0, 0, 2'b11, 0, 32'h20, 32'h55555555, 5'd0);
        tick();
        drive(1, 0, 0, 2'b11, 0, 32'h21, 32'h11111111, 5'd0);
        tick();
        check("mis_sw_flag", {31'b0, o_misaligned}, 32'h1);
        check("mis_sw_err",  {24'b0, o_err_count}, 32'd1);
        drive(0, 1, 1, 2'b11, 0, 32'h20, 32'h0, 5'd3);
        tick();
        check("mis_sw_flag_clr", {31'b0, o_misaligned}, 32'h0);
        check("mis_sw_nowrite",  o_read_data, 32'h55555555);
        drive(0, 1, 1, 2'b11, 0, 32'h22, 32'h0, 5'd3);
        tick();
        check("mis_lw_data", o_read_data, 32'h0);
        check("mis_lw_rw",   {31'b0, o_regWrite}, 32'h0);
        check("mis_lw_err",  {24'b0, o_err_count}, 32'd2);
        drive(0, 0, 1, 2'b01, 0, 32'h13, 32'h0, 5'd3);
        tick();
        check("noacc_mis", {31'b0, o_misaligned}, 32'h0);
        check("noacc_err", {24'b0, o_err_count}, 32'd2);
        check("noacc_rw",  {31'b0, o_regWrite}, 32'h1);
        drive(0, 1, 1, 2'b01, 0, 32'h13, 32'h0, 5'd3);
        tick();
        check("mis_lh_err", {24'b0, o_err_count}, 32'd3);
        for (int k = 0; k < 300; k++) begin
            drive(0, 1, 1, 2'b11, 0, 32'h23, 32'h0, 5'd3);
            tick();
        end
        check("err_saturate", {24'b0, o_err_count}, 32'd255);

        // read-before-write on combined load+store
        drive(1, 1, 1, 2'b11, 0, 32'h20, 32'h77777777, 5'd4);
        tick();
        check("rbw_old", o_read_data, 32'h55555555);
        drive(0, 1, 1, 2'b11, 0, 32'h20, 32'h0, 5'd4);
        tick();
        check("rbw_new", o_read_data, 32'h77777777);

        // hold with i_step
        drive(0, 1, 1, 2'b11, 0, 32'h10, 32'h0, 5'd7);
        tick();
        check("pre_hold", o_read_data, 32'h123400A5);
        i_step = 1'b1;
        drive(1, 0, 0, 2'b11, 0, 32'h14, 32'hAAAAAAAA, 5'd9);
        i_result = 32'h10;
        tick();
        check("hold_data",    o_read_data, 32'h123400A5);
        check("hold_wreg",    {27'b0, o_write_reg}, 32'd7);
        check("hold_mem2reg", {31'b0, o_mem2reg}, 32'h1);
        check("hold_result",  o_result, 32'h10);
`ifdef MEM_DBG_PORT_EN
        check("dbg_hold", o_dbg_data, 32'h123400A5);
`else
        check("dbg_off", o_dbg_data, 32'h0);
`endif
        tick();
        check("hold_nowrite_dbg", o_dbg_data,
`ifdef MEM_DBG_PORT_EN
              32'h123400A5
`else
              32'h0
`endif
        );
        i_step = 1'b0;
        tick();
        check("step_result", o_result, 32'h10);
        check("step_wreg",   {27'b0, o_write_reg}, 32'd9);
        drive(0, 1, 1, 2'b11, 0, 32'h10, 32'h0, 5'd7);
        tick();
        check("step_store", o_read_data, 32'hAAAAAAAA);
`ifdef MEM_DBG_PORT_EN
        check("dbg_after_store", o_dbg_data, 32'hAAAAAAAA);
`else
        check("dbg_off2", o_dbg_data, 32'h0);
`endif

        // asynchronous reset between edges
        #2 i_reset = 1'b1;
        #1;
        check("arst_readdata", o_read_data, 32'h0);
        check("arst_result",   o_result, 32'h0);
        check("arst_rw",       {31'b0, o_regWrite}, 32'h0);
        check("arst_err",      {24'b0, o_err_count}, 32'h0);
        check("arst_dbg",      o_dbg_data, 32'h0);
        #1 i_reset = 1'b0;
        tick();
        check("post_rst_load", o_read_data, 32'hAAAAAAAA);
        check("post_rst_err",  {24'b0, o_err_count}, 32'h0);

        idle();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
